sync_fifo_wr_arb: RTL and testbench

- Packet-atomic round-robin write arbiter that shares one sync FIFO write port among NREQ requesters.
- Sits directly in front of the team's sync FIFO instance. Drives its wr_en/wr_data and consumes its combinational full flag.
- Once a requester is granted, it keeps the grant until the beat flagged last is accepted. Packets from different requesters never interleave in the FIFO.

---
 rtl/sync_fifo_wr_arb.sv | 116 +++++++++++
 tb/tb_sync_fifo_wr_arb.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_wr_arb.sv
// Packet-atomic round-robin write arbiter in front of a sync FIFO write port.
// Optional build macro SYNC_FIFO_ARB_PRI0_EN gives requester 0 absolute priority at arbitration.
module sync_fifo_wr_arb #(
  parameter int W    = 8,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*W-1:0]   req_data,
  input  logic [NREQ-1:0]     req_last,
  output logic [NREQ-1:0]     ack,
  output logic                fifo_wr_en,
  output logic [W-1:0]        fifo_wr_data,
  input  logic                fifo_full,
  output logic                grant_vld,
  output logic [IDW-1:0]      grant_id
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] idx;
  logic           win_found;
  logic           pkt_done;

  // Winner search: first requester above the last-served one, wrapping at NREQ.
  always_comb begin
    win_id    = '0;
    win_found = 1'b0;
    idx       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(rr_ptr) + k) % NREQ);
      for (int i = 0; i < NREQ; i++) begin
        if (!win_found && idx == IDW'(i) && req[i]) begin
          win_found = 1'b1;
          win_id    = IDW'(i);
        end
      end
    end
`ifdef SYNC_FIFO_ARB_PRI0_EN
    if (req[0]) begin
      win_found = 1'b1;
      win_id    = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      rr_ptr    <= IDW'(NREQ - 1);
      grant_vld <= 1'b0;
      grant_id  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && win_found) begin
        grant_id  <= win_id;
        grant_vld <= 1'b1;
      end
      if (pkt_done) begin
        grant_vld <= 1'b0;
`ifdef SYNC_FIFO_ARB_PRI0_EN
        if (grant_id != '0) rr_ptr <= grant_id;
`else
        rr_ptr <= grant_id;
`endif
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (win_found) state_nxt = BUSY;
      BUSY: if (pkt_done)  state_nxt = IDLE;
    endcase
  end

  // Only the granted requester can be acked; data follows the grant in every BUSY cycle.
  always_comb begin
    ack          = '0;
    fifo_wr_data = '0;
    if (state == BUSY) begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant_id == IDW'(i)) begin
          fifo_wr_data = req_data[i*W +: W];
          ack[i]       = req[i] & ~fifo_full;
        end
      end
    end
  end

  assign fifo_wr_en = |ack;
  assign pkt_done   = |(ack & req_last);

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset_n) begin
      if (fifo_wr_en && fifo_full) begin
        $error("sync_fifo_wr_arb: write strobe while FIFO full");
        $stop;
      end
      if (!$onehot0(ack)) begin
        $error("sync_fifo_wr_arb: more than one ack bit high");
        $stop;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_wr_arb.sv
// Self-checking bench for sync_fifo_wr_arb: directed scenarios plus randomized packet traffic
// checked every cycle against a packet-level reference model.
module tb_sync_fifo_wr_arb;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   ack;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_wr_data;
  logic           fifo_full = 1'b0;
  logic           grant_vld;
  logic [1:0]     grant_id;

  sync_fifo_wr_arb #(.W(W), .NREQ(N), .IDW(2)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data), .req_last(req_last),
    .ack(ack), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full),
    .grant_vld(grant_vld), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // requester sources
  int pkts_left[N];
  int plen[N];
  int beat[N];
  int stall_left[N];
  int gap[N];
  logic [W-1:0] dat[N];
  bit rand_mode = 0;
  int full_pct = 0;
  int stall_pct = 0;
  int full_force = 0;

  // reference model
  bit m_busy = 0;
  int m_owner = 0;
  int m_ptr = N - 1;

  logic [W-1:0] wr_log[$];
  int wr_cyc[$];
  int grant_log[$];
  int cyc = 0;
  int cyc0 = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic int pick(logic [N-1:0] r, int ptr);
`ifdef SYNC_FIFO_ARB_PRI0_EN
    if (r[0]) return 0;
`endif
    for (int k = 1; k <= N; k++) if (r[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic void new_data(int i);
    if (rand_mode) dat[i] = W'($urandom);
    else dat[i] = W'(8'hA0 + 16 * beat[i] + i);
  endfunction

  function automatic void start(int i, int npk, int l);
    pkts_left[i] = npk;
    plen[i] = l;
    beat[i] = 0;
    stall_left[i] = 0;
    new_data(i);
  endfunction

  function automatic void advance(int i);
    beat[i]++;
    if (beat[i] == plen[i]) begin
      beat[i] = 0;
      pkts_left[i]--;
      if (pkts_left[i] > 0) begin
        stall_left[i] = gap[i];
        if (rand_mode) plen[i] = $urandom_range(1, 4);
      end
    end
    new_data(i);
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req[i] = (pkts_left[i] > 0) && (stall_left[i] == 0);
      req_data[i*W +: W] = dat[i];
      req_last[i] = (beat[i] == plen[i] - 1);
    end
    fifo_full = (full_force > 0) || (full_pct > 0 && $urandom_range(0, 99) < full_pct);
  endtask

  function automatic bit all_done();
    for (int i = 0; i < N; i++) if (pkts_left[i] > 0) return 0;
    return !m_busy;
  endfunction

  // One clock: compare at negedge, advance model and sources at posedge, drive #1 later.
  task automatic cycle();
    logic [N-1:0] ea;
    logic [W-1:0] ed;
    int w;
    @(negedge clk);
    ea = (m_busy && req[m_owner] && !fifo_full) ? (N'(1) << m_owner) : '0;
    ed = m_busy ? req_data[m_owner*W +: W] : '0;
    chk("ack", 32'(ack), 32'(ea));
    chk("wr_en", 32'(fifo_wr_en), 32'(|ea));
    chk("wr_data", 32'(fifo_wr_data), 32'(ed));
    chk("grant_vld", 32'(grant_vld), 32'(m_busy));
    if (m_busy) chk("grant_id", 32'(grant_id), 32'(m_owner));
    if (fifo_wr_en) begin
      wr_log.push_back(fifo_wr_data);
      wr_cyc.push_back(cyc - cyc0);
    end
    @(posedge clk);
    if (!m_busy) begin
      w = pick(req, m_ptr);
      if (w >= 0) begin
        m_busy = 1;
        m_owner = w;
        grant_log.push_back(w);
      end
    end else if (ea != '0 && req_last[m_owner]) begin
      m_busy = 0;
`ifdef SYNC_FIFO_ARB_PRI0_EN
      if (m_owner != 0) m_ptr = m_owner;
`else
      m_ptr = m_owner;
`endif
    end
    if (full_force > 0) full_force--;
    for (int i = 0; i < N; i++) if (stall_left[i] > 0) stall_left[i]--;
    for (int i = 0; i < N; i++) if (ea[i]) advance(i);
    for (int i = 0; i < N; i++)
      if (stall_pct > 0 && pkts_left[i] > 0 && beat[i] > 0 && stall_left[i] == 0 &&
          $urandom_range(0, 99) < stall_pct)
        stall_left[i] = $urandom_range(1, 3);
    cyc++;
    #1 drive();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      pkts_left[i] = 0; beat[i] = 0; plen[i] = 1; stall_left[i] = 0; gap[i] = 0;
    end
    rand_mode = 0; full_pct = 0; stall_pct = 0; full_force = 0;
    m_busy = 0; m_owner = 0; m_ptr = N - 1;
    drive();
    #1;
    chk("rst_ack", 32'(ack), 0);
    chk("rst_wr_en", 32'(fifo_wr_en), 0);
    chk("rst_wr_data", 32'(fifo_wr_data), 0);
    chk("rst_grant_vld", 32'(grant_vld), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    wr_log.delete(); wr_cyc.delete(); grant_log.delete();
  endtask

  task automatic run_until_idle(int budget);
    int n = 0;
    while (!all_done() && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_in_budget", 32'(all_done()), 1);
  endtask

  task automatic wait_writes(int k, int budget);
    int n = 0;
    while (wr_log.size() < k && n < budget) begin
      cycle();
      n++;
    end
    chk("writes_reached", 32'(wr_log.size()), 32'(k));
  endtask

  initial begin
    logic [W-1:0] exp1[8];
    int exp_cyc[8];
    int exp_ord[$];

    // 1: four 2-beat packets, round robin from requester 0, one bubble between packets
    do_reset();
    for (int i = 0; i < N; i++) start(i, 1, 2);
    drive();
    cyc0 = cyc;
    run_until_idle(40);
    exp1 = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2, 8'hA3, 8'hB3};
    exp_cyc = '{1, 2, 4, 5, 7, 8, 10, 11};
    chk("t1_count", 32'(wr_log.size()), 8);
    for (int k = 0; k < 8 && k < wr_log.size(); k++) begin
      chk("t1_data", 32'(wr_log[k]), 32'(exp1[k]));
      chk("t1_cycle", 32'(wr_cyc[k]), 32'(exp_cyc[k]));
    end

    // 2: requester 2 alone, FIFO full for 3 cycles after beat 2
    do_reset();
    start(2, 1, 4);
    drive();
    wait_writes(2, 20);
    full_force = 3;
    drive();
    repeat (3) begin
      #2;
      chk("t2_full_ack", 32'(ack), 0);
      chk("t2_full_gid", 32'(grant_id), 2);
      chk("t2_full_gvld", 32'(grant_vld), 1);
      cycle();
    end
    run_until_idle(20);
    chk("t2_count", 32'(wr_log.size()), 4);
    for (int k = 0; k < 4 && k < wr_log.size(); k++)
      chk("t2_data", 32'(wr_log[k]), 32'(8'hA2 + 16 * k));

    // 3: requester 1 stalls mid-packet, requester 3 waits throughout
    do_reset();
    start(1, 1, 3);
    start(3, 1, 1);
    drive();
    wait_writes(1, 20);
    stall_left[1] = 2;
    drive();
    repeat (2) begin
      #2;
      chk("t3_stall_ack", 32'(ack), 0);
      chk("t3_stall_gid", 32'(grant_id), 1);
      cycle();
    end
    run_until_idle(30);
    chk("t3_grants", 32'(grant_log.size()), 2);
    if (grant_log.size() == 2) begin
      chk("t3_first", 32'(grant_log[0]), 1);
      chk("t3_second", 32'(grant_log[1]), 3);
    end
    chk("t3_last_data", 32'(wr_log[wr_log.size()-1]), 32'(8'hA3));

    // 4: reset during beat 2 of a 3-beat packet, then requesters 0 and 1
    do_reset();
    start(1, 1, 3);
    drive();
    wait_writes(1, 20);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t4_async_gvld", 32'(grant_vld), 0);
    chk("t4_async_wr_en", 32'(fifo_wr_en), 0);
    chk("t4_async_ack", 32'(ack), 0);
    do_reset();
    start(0, 1, 1);
    start(1, 1, 1);
    drive();
    run_until_idle(20);
    chk("t4_first_grant", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 0);

    // 5: requester 0 re-requests after each of its packets
    do_reset();
    start(0, 3, 1);
    gap[0] = 1;
    for (int i = 1; i < N; i++) start(i, 1, 1);
    drive();
    run_until_idle(60);
`ifdef SYNC_FIFO_ARB_PRI0_EN
    exp_ord = '{0, 1, 0, 2, 0, 3};
`else
    exp_ord = '{0, 1, 2, 3};
`endif
    for (int k = 0; k < exp_ord.size(); k++)
      chk("t5_order", 32'(k < grant_log.size() ? grant_log[k] : -1), 32'(exp_ord[k]));

    // 6: randomized traffic with full, stalls and inter-packet gaps
    do_reset();
    rand_mode = 1;
    full_pct = 20;
    stall_pct = 15;
    for (int i = 0; i < N; i++) begin
      gap[i] = $urandom_range(0, 2);
      start(i, $urandom_range(3, 8), $urandom_range(1, 4));
    end
    drive();
    run_until_idle(4000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
